// File: rtl/msg_sequencer.sv
// -----------------------------------------------------------------------------
// msg_sequencer
//
// Sends one message to a serial transmitter. On a start request the message
// selector is latched and its descriptor (ROM base address, length) is read from
// an external descriptor table. Characters are then fetched one by one from a
// synchronous character ROM. Each one is handed to the transmitter with a
// one-cycle start strobe, and consecutive strobes are held at least CHAR_GAP
// cycles apart. An optional auto-repeat mode raises a start request every
// AUTO_PERIOD cycles.
//
// Ports
//   sysclk       system clock, rising edge
//   rst_n        asynchronous active-low reset
//   active       enable for trig / auto_toggle
//   sel          message selector, latched when a message starts
//   trig         single-cycle send request
//   auto_toggle  single-cycle pulse that toggles auto-repeat mode
//   desc_sel     latched selector presented to the descriptor table
//   desc_base    first ROM address of the selected message (combinational)
//   desc_len     character count of the selected message (combinational)
//   rom_addr     character ROM address
//   rom_data     ROM data, valid one cycle after rom_addr
//   tx_data      character to the transmitter
//   tx_start     one-cycle start strobe to the transmitter
//   tx_busy      transmitter busy, blocks tx_start while high
//   busy         high from LOAD until DONE inclusive
//   auto_on      auto-repeat mode state
//   done         one-cycle pulse at the end of a message
//   char_cnt     characters sent in the current message
// -----------------------------------------------------------------------------
module msg_sequencer #(
    parameter int SEL_W       = 4,
    parameter int ADDR_W      = 6,
    parameter int LEN_W       = 6,
    parameter int DATA_W      = 8,
    parameter int CHAR_GAP    = 78105,
    parameter int AUTO_PERIOD = 33554432
) (
    input  logic              sysclk,
    input  logic              rst_n,
    input  logic              active,
    input  logic [SEL_W-1:0]  sel,
    input  logic              trig,
    input  logic              auto_toggle,
    output logic [SEL_W-1:0]  desc_sel,
    input  logic [ADDR_W-1:0] desc_base,
    input  logic [LEN_W-1:0]  desc_len,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic              busy,
    output logic              auto_on,
    output logic              done,
    output logic [LEN_W-1:0]  char_cnt
);

    // -------------------------------------------------------------------------
    // state  | meaning
    // -------+-----------------------------------------------------------------
    // IDLE   | waiting for a start request (trig or auto pending)
    // LOAD   | desc_sel valid, capture base/len from the descriptor table
    // FETCH  | rom_addr holds the next character address, ROM is reading
    // WAIT   | capture ROM data, hold until transmitter idle and gap expired
    // SEND   | tx_start high for this single cycle
    // DONE   | done high for this single cycle, then back to IDLE
    // -------------------------------------------------------------------------
    // Outputs are registered and change on the edge that enters each state, so
    // tx_start is high during SEND, done during DONE and busy from LOAD to DONE.

    localparam int GAP_W  = (CHAR_GAP > 2) ? $clog2(CHAR_GAP) : 1;
    localparam int AUTO_W = $clog2(AUTO_PERIOD);

    localparam logic [GAP_W-1:0]  GAP_RELOAD = GAP_W'(CHAR_GAP - 1);
    localparam logic [AUTO_W-1:0] AUTO_LAST  = AUTO_W'(AUTO_PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_FETCH = 3'd2,
        S_WAIT  = 3'd3,
        S_SEND  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   base_q;
    logic [LEN_W-1:0]    len_q;
    logic                first_wait;
    logic [GAP_W-1:0]    gap_cnt;
    logic [AUTO_W-1:0]   auto_cnt;
    logic                auto_pend;

    logic                toggle_hit;
    logic                auto_wrap;
    logic                start_req;
    logic                wait_ok;

    assign toggle_hit = active && auto_toggle;
    assign auto_wrap  = auto_on && (auto_cnt == AUTO_LAST);
    // A trig that coincides with a pending auto request is one request.
    assign start_req  = (active && trig) || auto_pend;
    assign wait_ok    = !tx_busy && (gap_cnt == '0);

    // -------------------------------------------------------------------------
    // Auto-repeat mode: free-running period counter and a single-entry pending
    // flag. The flag waits for IDLE; wraps while it is already set are lost.
    // -------------------------------------------------------------------------
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            auto_on   <= 1'b0;
            auto_cnt  <= '0;
            auto_pend <= 1'b0;
        end else if (toggle_hit && auto_on) begin
            // Switching off: drop any pending request, the running message
            // still completes because the FSM does not look at auto_on.
            auto_on   <= 1'b0;
            auto_cnt  <= '0;
            auto_pend <= 1'b0;
        end else begin
            if (toggle_hit) begin
                auto_on <= 1'b1;
            end
            if (auto_on) begin
                auto_cnt <= auto_wrap ? '0 : auto_cnt + AUTO_W'(1);
            end
            if (auto_wrap) begin
                auto_pend <= 1'b1;
            end else if (state == S_IDLE) begin
                auto_pend <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Message FSM with registered outputs and the inter-character gap counter.
    // -------------------------------------------------------------------------
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            desc_sel   <= '0;
            base_q     <= '0;
            len_q      <= '0;
            first_wait <= 1'b0;
            rom_addr   <= '0;
            tx_data    <= '0;
            tx_start   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            char_cnt   <= '0;
            gap_cnt    <= '0;
        end else begin
            tx_start <= 1'b0;
            done     <= 1'b0;

            // Runs in every state; the reload on entry to SEND overrides it.
            if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end

            case (state)
                S_IDLE: begin
                    if (start_req) begin
                        desc_sel <= sel;
                        char_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    base_q <= desc_base;
                    len_q  <= desc_len;
                    if (desc_len == '0) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        // base_q is not loaded yet, so address straight from
                        // the descriptor table for the first character.
                        rom_addr <= desc_base;
                        state    <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    first_wait <= 1'b1;
                    state      <= S_WAIT;
                end

                S_WAIT: begin
                    first_wait <= 1'b0;
                    if (first_wait) begin
                        tx_data <= rom_data;
                    end
                    if (wait_ok) begin
                        tx_start <= 1'b1;
                        gap_cnt  <= GAP_RELOAD;
                        char_cnt <= char_cnt + LEN_W'(1);
                        state    <= S_SEND;
                    end
                end

                S_SEND: begin
                    // char_cnt already counts the character on the wire.
                    if (char_cnt == len_q) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        rom_addr <= base_q + ADDR_W'(char_cnt);
                        state    <= S_FETCH;
                    end
                end

                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_msg_sequencer.sv
module tb_msg_sequencer;

    localparam int SEL_W       = 4;
    localparam int ADDR_W      = 6;
    localparam int LEN_W       = 6;
    localparam int DATA_W      = 8;
    localparam int CHAR_GAP    = 4;
    localparam int AUTO_PERIOD = 32;
    // Back-to-back characters need SEND, FETCH, WAIT at least.
    localparam int SP          = (CHAR_GAP > 3) ? CHAR_GAP : 3;
    localparam int ROM_SIZE    = 1 << ADDR_W;

    logic              sysclk;
    logic              rst_n;
    logic              active;
    logic [SEL_W-1:0]  sel;
    logic              trig;
    logic              auto_toggle;
    logic [SEL_W-1:0]  desc_sel;
    logic [ADDR_W-1:0] desc_base;
    logic [LEN_W-1:0]  desc_len;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] tx_data;
    logic              tx_start;
    logic              tx_busy;
    logic              busy;
    logic              auto_on;
    logic              done;
    logic [LEN_W-1:0]  char_cnt;

    logic [ADDR_W-1:0] dbase   [1 << SEL_W];
    logic [LEN_W-1:0]  dlen    [1 << SEL_W];
    logic [DATA_W-1:0] rom_mem [ROM_SIZE];

    int checks = 0;
    int errors = 0;

    msg_sequencer #(
        .SEL_W      (SEL_W),
        .ADDR_W     (ADDR_W),
        .LEN_W      (LEN_W),
        .DATA_W     (DATA_W),
        .CHAR_GAP   (CHAR_GAP),
        .AUTO_PERIOD(AUTO_PERIOD)
    ) dut (
        .sysclk     (sysclk),
        .rst_n      (rst_n),
        .active     (active),
        .sel        (sel),
        .trig       (trig),
        .auto_toggle(auto_toggle),
        .desc_sel   (desc_sel),
        .desc_base  (desc_base),
        .desc_len   (desc_len),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .busy       (busy),
        .auto_on    (auto_on),
        .done       (done),
        .char_cnt   (char_cnt)
    );

    // Descriptor table is combinational from desc_sel.
    assign desc_base = dbase[desc_sel];
    assign desc_len  = dlen[desc_sel];

    initial begin
        sysclk = 1'b0;
        forever #5 sysclk = ~sysclk;
    end

    // Synchronous ROM: address seen at a rising edge, data one cycle later.
    initial begin
        logic [ADDR_W-1:0] a;
        rom_data = '0;
        forever begin
            @(negedge sysclk);
            a = rom_addr;
            @(posedge sysclk);
            #1 rom_data = rom_mem[a];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge sysclk);
        #1;
    endtask

    // One message started by trig in cycle 0. tx_busy is high in cycles
    // [blo, bhi]. Expected strobe cycles: the first at 4, each next one SP
    // after the previous; a strobe whose deciding WAIT cycle sees tx_busy
    // slips to the cycle after tx_busy falls.
    task automatic send_msg(input string tag, input int s, input int blo, input int bhi,
                            input bit chg_sel);
        int base;
        int len;
        int t;
        int done_off;
        int idx;
        int starts[$];
        bit exp_start;
        bit in_msg;
        base = int'(dbase[s]);
        len  = int'(dlen[s]);
        for (int i = 0; i < len; i++) begin
            t = (i == 0) ? 4 : starts[i-1] + SP;
            if (t - 1 >= blo && t - 1 <= bhi) t = bhi + 2;
            starts.push_back(t);
        end
        done_off = (len == 0) ? 2 : starts[len-1] + 1;
        idx = 0;
        sel  = SEL_W'(s);
        trig = 1'b1;
        for (int k = 0; k <= done_off + 1; k++) begin
            tx_busy = (k >= blo && k <= bhi);
            #1;
            exp_start = (idx < len) && (starts[idx] == k);
            in_msg    = (k >= 1 && k <= done_off);
            check({tag, " tx_start"}, 32'(tx_start), 32'(exp_start));
            check({tag, " done"}, 32'(done), 32'(k == done_off));
            check({tag, " busy"}, 32'(busy), 32'(in_msg));
            if (in_msg) check({tag, " desc_sel"}, 32'(desc_sel), 32'(s));
            if (exp_start) begin
                check({tag, " tx_data"}, 32'(tx_data), 32'(rom_mem[(base + idx) % ROM_SIZE]));
                check({tag, " rom_addr"}, 32'(rom_addr), 32'((base + idx) % ROM_SIZE));
                idx++;
            end
            if (k == done_off) check({tag, " char_cnt"}, 32'(char_cnt), 32'(len));
            next_cycle();
            if (k == 0) begin
                trig = 1'b0;
                if (chg_sel) sel = SEL_W'($urandom_range(0, (1 << SEL_W) - 1));
            end
        end
        tx_busy = 1'b0;
    endtask

    initial begin
        int toff;
        int load_m;
        int base2;
        int nstart;
        bit exp_start;
        int blo;
        int bhi;

        rst_n       = 1'b0;
        active      = 1'b1;
        sel         = '0;
        trig        = 1'b0;
        auto_toggle = 1'b0;
        tx_busy     = 1'b0;

        for (int i = 0; i < ROM_SIZE; i++) rom_mem[i] = DATA_W'($urandom);
        rom_mem[0] = 8'h41;
        rom_mem[1] = 8'h42;
        rom_mem[2] = 8'h43;
        for (int i = 0; i < (1 << SEL_W); i++) begin
            dbase[i] = ADDR_W'($urandom_range(0, ROM_SIZE - 1));
            dlen[i]  = LEN_W'($urandom_range(0, 6));
        end
        dbase[3] = 0;  dlen[3] = 3;
        dbase[5] = 62; dlen[5] = 4;
        dlen[7]  = 0;
        dbase[2] = 10; dlen[2] = 2;

        // Reset values
        repeat (3) @(posedge sysclk);
        #1;
        check("rst tx_start", 32'(tx_start), 0);
        check("rst busy", 32'(busy), 0);
        check("rst done", 32'(done), 0);
        check("rst auto_on", 32'(auto_on), 0);
        check("rst char_cnt", 32'(char_cnt), 0);
        check("rst rom_addr", 32'(rom_addr), 0);
        check("rst tx_data", 32'(tx_data), 0);
        check("rst desc_sel", 32'(desc_sel), 0);
        rst_n = 1'b1;
        next_cycle();
        next_cycle();

        // "ABC", free transmitter
        send_msg("abc", 3, -1, -2, 1'b0);
        // zero-length message
        send_msg("len0", 7, -1, -2, 1'b0);
        // transmitter busy for 20 cycles from the first strobe
        send_msg("txbusy", 3, 4, 23, 1'b0);
        // ROM address wrap 62, 63, 0, 1 with selector changed mid-message
        send_msg("wrap", 5, -1, -2, 1'b1);

        // Auto-repeat: on in cycle 0, off during the third message.
        // Wrap m lands at cycle AUTO_PERIOD*(m+1); its LOAD two cycles later.
        toff  = 3 * AUTO_PERIOD + 4;
        base2 = int'(dbase[2]);
        sel   = 2;
        nstart = 0;
        for (int k = 0; k < 6 * AUTO_PERIOD; k++) begin
            auto_toggle = (k == 0 || k == toff);
            #1;
            exp_start = 1'b0;
            for (int m = 0; AUTO_PERIOD * (m + 1) <= toff; m++) begin
                load_m = AUTO_PERIOD * (m + 1) + 2;
                if (k == load_m + 3 || k == load_m + 3 + SP) exp_start = 1'b1;
            end
            check("auto tx_start", 32'(tx_start), 32'(exp_start));
            check("auto auto_on", 32'(auto_on), 32'(k >= 1 && k <= toff));
            if (exp_start) begin
                check("auto tx_data", 32'(tx_data), 32'(rom_mem[(base2 + (nstart % 2)) % ROM_SIZE]));
                nstart++;
            end
            next_cycle();
        end
        auto_toggle = 1'b0;
        check("auto strobes", 32'(nstart), 6);

        // Reset in WAIT with auto mode on: everything clears at once.
        sel = 5;
        trig = 1'b1;
        auto_toggle = 1'b1;
        next_cycle();
        trig = 1'b0;
        auto_toggle = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b0;
        #1;
        check("arst tx_start", 32'(tx_start), 0);
        check("arst busy", 32'(busy), 0);
        check("arst auto_on", 32'(auto_on), 0);
        check("arst char_cnt", 32'(char_cnt), 0);
        check("arst rom_addr", 32'(rom_addr), 0);
        check("arst tx_data", 32'(tx_data), 0);
        check("arst desc_sel", 32'(desc_sel), 0);
        next_cycle();
        rst_n = 1'b1;
        // No leftover auto request may start a message.
        for (int k = 0; k < 2 * AUTO_PERIOD; k++) begin
            next_cycle();
            check("post-rst idle", 32'(busy), 0);
        end
        send_msg("restart", 3, -1, -2, 1'b0);

        // active low: trig and auto_toggle ignored
        active = 1'b0;
        trig = 1'b1;
        auto_toggle = 1'b1;
        next_cycle();
        trig = 1'b0;
        auto_toggle = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("inactive busy", 32'(busy), 0);
            check("inactive auto_on", 32'(auto_on), 0);
            next_cycle();
        end
        active = 1'b1;

        // Randomized messages
        for (int n = 0; n < 25; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                blo = $urandom_range(0, 12);
                bhi = blo + $urandom_range(0, 10);
            end else begin
                blo = -1;
                bhi = -2;
            end
            send_msg("rand", $urandom_range(0, (1 << SEL_W) - 1), blo, bhi,
                     1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
